// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response types and the interface bundling them.
// The master drives dreq and holds it until data_ok; the slave answers on dresp.
package dbus_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// Handshake: a request is accepted in the cycle dreq.valid and dresp.addr_ok are
// both high; it completes in the single cycle dresp.data_ok is high. Dropping
// dreq.valid before that cycle abandons the request.
interface dbus_sram_responder_if;
  dbus_pkg::dbus_req_t  dreq;
  dbus_pkg::dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a 64-bit-word synchronous SRAM model.
// Optional feature macro: DBUS_RESP_RANDOM_DELAY_EN (LFSR-driven 0..3 extra wait cycles).
module dbus_sram_responder #(
  parameter int WORDS   = 4096,
  parameter int LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  dbus_sram_responder_if.slave         bus,
  output logic [1:0]                   dbg_state
);
  localparam int IW = $clog2(WORDS);
`ifdef DBUS_RESP_RANDOM_DELAY_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      strb_q, strb_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [CW-1:0]   load_val;
  logic            accept;
  logic            commit;
  logic [IW-1:0]   req_idx;
  logic [IW-1:0]   rd_idx;
  logic [63:0]     rdata_q;
  logic [63:0]     mem_q [WORDS];
`ifdef DBUS_RESP_RANDOM_DELAY_EN
  logic [7:0]      lfsr_q, lfsr_d;
`endif

  // Byte offset, high address bits and size never influence the access.
  logic unused_bits;
  assign unused_bits = ^{bus.dreq.addr[63:3+IW], bus.dreq.addr[2:0], bus.dreq.size};

  assign req_idx   = bus.dreq.addr[3 +: IW];
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    accept   = 1'b0;
    commit   = 1'b0;
`ifdef DBUS_RESP_RANDOM_DELAY_EN
    lfsr_d   = lfsr_q;
    load_val = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
    load_val = CW'(LATENCY - 1);
`endif
    case (state_q)
      IDLE: begin
        if (bus.dreq.valid) begin
          accept  = 1'b1;
          idx_d   = req_idx;
          strb_d  = bus.dreq.strobe;
          wdata_d = bus.dreq.data;
          cnt_d   = load_val;
          state_d = (load_val == '0) ? RESP : BUSY;
`ifdef DBUS_RESP_RANDOM_DELAY_EN
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        end
      end
      BUSY: begin
        if (!bus.dreq.valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RESP;
        end
      end
      RESP: begin
        commit  = bus.dreq.valid && !reset;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
`ifdef DBUS_RESP_RANDOM_DELAY_EN
      lfsr_q  <= 8'hA5;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
`ifdef DBUS_RESP_RANDOM_DELAY_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // The read port samples the request address in IDLE so a zero-wait access
  // already has its word registered when RESP begins; the write lands on the
  // edge leaving RESP, so RESP always presents the pre-write contents.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[rd_idx];
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        if (strb_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.dresp         = '0;
    bus.dresp.addr_ok = accept && !reset;
    bus.dresp.data_ok = (state_q == RESP) && bus.dreq.valid && !reset;
    bus.dresp.data    = bus.dresp.data_ok ? rdata_q : 64'h0;
  end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: reads, byte writes, wrap, abandon,
// mid-transaction reset and back-to-back latency against a small LFSR model.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int LATENCY = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbus_sram_responder_if bus();
  logic [1:0] dbg_state;

  dbus_sram_responder #(.WORDS(4096), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  lfsr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected wait for the next accepted request; advances the LFSR model.
  task automatic model_accept(output int lat);
    lat = LATENCY;
`ifdef DBUS_RESP_RANDOM_DELAY_EN
    lat += int'(lfsr_m[1:0]);
`endif
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  endtask

  // Driver tasks: called at posedge+1, return at posedge+1.
  task automatic drive(input logic v, input logic [63:0] addr, input logic [7:0] strb,
                       input logic [63:0] wdata);
    bus.dreq.valid  = v;
    bus.dreq.addr   = addr;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = strb;
    bus.dreq.data   = wdata;
  endtask

  task automatic xact(input string tag, input logic [63:0] addr, input logic [7:0] strb,
                      input logic [63:0] wdata, input logic chk_data);
    int lat;
    int got;
    model_accept(lat);
    drive(1'b1, addr, strb, wdata);
    @(negedge clk);
    chk({tag, ".addr_ok_accept"}, 64'(bus.dresp.addr_ok), 64'd1);
    chk({tag, ".data_ok_accept"}, 64'(bus.dresp.data_ok), 64'd0);
    got = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      got++;
      if (!bus.dresp.data_ok) begin
        chk({tag, ".addr_ok_busy"}, 64'(bus.dresp.addr_ok), 64'd0);
        chk({tag, ".data_busy"}, bus.dresp.data, 64'h0);
      end
    end while (!bus.dresp.data_ok && got < 20);
    chk({tag, ".latency"}, 64'(got), 64'(lat));
    if (chk_data) chk({tag, ".rdata"}, bus.dresp.data, exp_q.pop_front());
    @(posedge clk);
    #1;
    chk({tag, ".back_to_idle"}, 64'(dbg_state), 64'd0);
    bus.dreq.valid = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    drive(1'b0, 64'h0, 8'h0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 64'h28, 8'h00, 64'h0);
    #1;
    chk("reset.addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
    chk("reset.data_ok", 64'(bus.dresp.data_ok), 64'd0);
    chk("reset.data", bus.dresp.data, 64'h0);
    chk("reset.state", 64'(dbg_state), 64'd0);
    bus.dreq.valid = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    lfsr_m = 8'hA5;

    // Preload words 5 and 7, then read word 5.
    xact("wr5", 64'h28, 8'hFF, 64'h1122334455667788, 1'b0);
    xact("wr7", 64'h38, 8'hFF, 64'h0102030405060708, 1'b0);
    exp_q.push_back(64'h1122334455667788);
    xact("rd5", 64'h28, 8'h00, 64'h0, 1'b1);

    // Single-lane write then back-to-back read of the same word.
    xact("bytewr", 64'h2B, 8'h08, 64'h00000000AB000000, 1'b0);
    exp_q.push_back(64'h11223344AB667788);
    xact("rd5_byte", 64'h28, 8'h00, 64'h0, 1'b1);

    // Address wraps modulo WORDS*8.
    xact("wrap_wr", 64'h8028, 8'hFF, 64'h00000000DEADBEEF, 1'b0);
    exp_q.push_back(64'h00000000DEADBEEF);
    xact("wrap_rd", 64'h28, 8'h00, 64'h0, 1'b1);

    // Abandon in BUSY.
    model_accept(lat);
    drive(1'b1, 64'h38, 8'hFF, 64'h00000000000000FF);
    @(negedge clk);
    chk("abn_busy.addr_ok", 64'(bus.dresp.addr_ok), 64'd1);
    @(posedge clk);
    #1;
    bus.dreq.valid = 1'b0;
    @(negedge clk);
    chk("abn_busy.data_ok", 64'(bus.dresp.data_ok), 64'd0);
    chk("abn_busy.addr_ok_busy", 64'(bus.dresp.addr_ok), 64'd0);
    @(posedge clk);
    #1;
    chk("abn_busy.idle", 64'(dbg_state), 64'd0);
    exp_q.push_back(64'h0102030405060708);
    xact("abn_busy_rd7", 64'h38, 8'h00, 64'h0, 1'b1);

    // Abandon in RESP.
    model_accept(lat);
    drive(1'b1, 64'h38, 8'hFF, 64'h00000000000000FF);
    @(negedge clk);
    chk("abn_resp.addr_ok", 64'(bus.dresp.addr_ok), 64'd1);
    repeat (lat) @(posedge clk);
    #1;
    bus.dreq.valid = 1'b0;
    @(negedge clk);
    chk("abn_resp.data_ok", 64'(bus.dresp.data_ok), 64'd0);
    chk("abn_resp.data", bus.dresp.data, 64'h0);
    @(posedge clk);
    #1;
    chk("abn_resp.idle", 64'(dbg_state), 64'd0);
    exp_q.push_back(64'h0102030405060708);
    xact("abn_resp_rd7", 64'h38, 8'h00, 64'h0, 1'b1);

    // Reset one cycle after accepting a write to word 7.
    model_accept(lat);
    drive(1'b1, 64'h38, 8'hFF, 64'h00000000000000FF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid.addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
    chk("rst_mid.data_ok", 64'(bus.dresp.data_ok), 64'd0);
    chk("rst_mid.data", bus.dresp.data, 64'h0);
    chk("rst_mid.state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    lfsr_m         = 8'hA5;
    bus.dreq.valid = 1'b0;
    exp_q.push_back(64'h0102030405060708);
    xact("rst_mid_rd7", 64'h38, 8'h00, 64'h0, 1'b1);

    // 16 back-to-back reads alternating words 5 and 7.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        exp_q.push_back(64'h00000000DEADBEEF);
        xact("b2b_rd5", 64'h28, 8'h00, 64'h0, 1'b1);
      end else begin
        exp_q.push_back(64'h0102030405060708);
        xact("b2b_rd7", 64'h38, 8'h00, 64'h0, 1'b1);
      end
    end

    // After reset the delay sequence restarts from the seed.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    lfsr_m = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'h00000000DEADBEEF);
      xact("repeat_rd5", 64'h28, 8'h00, 64'h0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
